// File: rtl/audio_sample_fifo.sv
// ============================================================================
// Module   : audio_sample_fifo
// Brief    : Stereo frame FIFO that pairs 24-bit left/right words into 48-bit
//            frames and drains them show-ahead to the codec interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_sample_fifo #(
  parameter int DEPTH    = 16,
  parameter int LOW_MARK = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push_left,
  input  logic                     i_push_right,
  input  logic [23:0]              i_push_data,
  input  logic                     i_flush,
  input  logic                     i_clr_overflow,
  output logic [47:0]              o_audio_out,
  output logic                     o_audio_out_valid,
  input  logic                     i_sink_full,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_low_water,
  output logic                     o_overflow
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;
  localparam logic [c_LVL_W-1:0] c_DEPTH_LVL = c_LVL_W'(DEPTH);
  localparam logic [c_LVL_W-1:0] c_LOW_LVL   = c_LVL_W'(LOW_MARK);

  logic [47:0]         r_mem [DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_LVL_W-1:0]  r_level;
  logic [23:0]         r_left_hold;
  logic                r_overflow;

  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_accept;
  logic                w_drop;
  logic [47:0]         w_frame;

  // Status is derived from the registered level only, never from the strobes.
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_DEPTH_LVL);

  // Flush suppresses both sides of the queue for the cycle it is asserted.
  assign w_pop    = !w_empty && !i_sink_full && !i_flush;
  assign w_accept = i_push_right && !i_flush && (!w_full || w_pop);
  assign w_drop   = i_push_right && !i_flush && w_full && !w_pop;

  // A simultaneous left/right strobe forms a mono frame from the same word.
  assign w_frame = i_push_left ? {i_push_data, i_push_data}
                               : {r_left_hold, i_push_data};

  always_ff @(posedge clk) begin
    if (resetn && w_accept) begin
      r_mem[r_wr_ptr] <= w_frame;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_left_hold <= '0;
    end else if (i_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_left_hold <= '0;
    end else begin
      if (i_push_left) begin
        r_left_hold <= i_push_data;
      end
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_audio_out       = r_mem[r_rd_ptr];
  assign o_audio_out_valid = !w_empty;
  assign o_level           = r_level;
  assign o_empty           = w_empty;
  assign o_full            = w_full;
  assign o_low_water       = (r_level <= c_LOW_LVL);
  assign o_overflow        = r_overflow;

endmodule

`default_nettype wire
